// File: rtl/can_tx_scheduler_pkg.sv
// Shared types and defaults for the CAN transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package can_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ID_W      = 11;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_TIMEOUT   = 64;
    localparam int DEF_MAX_RETRY = 2;

    // Low bit of entry idx inside a vector packing entries of width w back to back.
    function automatic int pk_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/can_tx_scheduler_prio_arbiter.sv
// Picks the occupied mailbox with the lowest ID; ties go to the lowest index.
// Latency: purely combinational.
// Backpressure: none; result is only consumed by the scheduler while idle.
module can_prio_arbiter
    import can_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0]      full,
    input  logic [NUM_REQ*ID_W-1:0] ids,
    output logic                    any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int SEL_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] best_id;

    // Ascending scan with strict compare keeps the lowest index on equal IDs.
    always_comb begin
        any     = 1'b0;
        idx     = '0;
        best_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full[i] && (!any || (ids[pk_lo(i, ID_W) +: ID_W] < best_id))) begin
                any     = 1'b1;
                idx     = SEL_W'(i);
                best_id = ids[pk_lo(i, ID_W) +: ID_W];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares the CAN controller transmit path between NUM_REQ one-entry mailboxes, lowest ID first.
// Latency: accept to ctl_tx_req 2 cycles; ctl_tx_done to done 1 cycle; mailbox free 1 cycle after done.
// Backpressure: req_ready[i] stays low while mailbox i holds a frame, through all retries.
module can_tx_scheduler
    import can_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_W      = DEF_ID_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ID_W-1:0]       req_id,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_W-1:0]             ctl_data_in,
    output logic                          ctl_tx_req,
    input  logic                          ctl_tx_done,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    cur_sel
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    sched_state_t               state_q, state_d;
    logic [NUM_REQ-1:0]         full_q, full_d;
    logic [NUM_REQ*ID_W-1:0]    mb_id_q, mb_id_d;
    logic [NUM_REQ*DATA_W-1:0]  mb_data_q, mb_data_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [RTY_W-1:0]           retry_q, retry_d;
    logic [DATA_W-1:0]          dout_q, dout_d;
    logic                       tx_req_q, tx_req_d;
    logic [NUM_REQ-1:0]         done_q, done_d;
    logic [NUM_REQ-1:0]         err_q, err_d;

    logic                       win_any;
    logic [SEL_W-1:0]           win_idx;

    can_prio_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .full (full_q),
        .ids  (mb_id_q),
        .any  (win_any),
        .idx  (win_idx)
    );

    // Mailboxes: load on handshake, free only when the scheduler leaves CLEAR.
    always_comb begin
        full_d    = full_q;
        mb_id_d   = mb_id_q;
        mb_data_d = mb_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !full_q[i]) begin
                full_d[i]                                = 1'b1;
                mb_id_d[pk_lo(i, ID_W) +: ID_W]          = req_id[pk_lo(i, ID_W) +: ID_W];
                mb_data_d[pk_lo(i, DATA_W) +: DATA_W]    = req_data[pk_lo(i, DATA_W) +: DATA_W];
            end
        end
        if (state_q == ST_CLEAR) begin
            full_d[sel_q] = 1'b0;
        end
    end

    // Service FSM; every output is computed for the next state so it leaves a flop.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        dout_d   = dout_q;
        tx_req_d = 1'b0;
        done_d   = '0;
        err_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    sel_d    = win_idx;
                    retry_d  = '0;
                    dout_d   = mb_data_q[pk_lo(int'(win_idx), DATA_W) +: DATA_W];
                    tx_req_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctl_tx_done) begin
                    done_d[sel_q] = 1'b1;
                    state_d       = ST_CLEAR;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d  = retry_q + 1'b1;
                        tx_req_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        err_d[sel_q] = 1'b1;
                        state_d      = ST_CLEAR;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                dout_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                dout_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, mailboxes and registered outputs; reset drops any frame in flight silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            full_q    <= '0;
            mb_id_q   <= '0;
            mb_data_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            dout_q    <= '0;
            tx_req_q  <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            mb_id_q   <= mb_id_d;
            mb_data_q <= mb_data_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dout_q    <= dout_d;
            tx_req_q  <= tx_req_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = ~full_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ctl_data_in = dout_q;
    assign ctl_tx_req  = tx_req_q;
    assign busy        = (state_q != ST_IDLE);
    assign cur_sel     = sel_q;

endmodule
